// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// Oversampling UART receiver. The serial line is synchronised, then sampled
// by a state machine running off a free-running oversample tick. Each bit is
// sampled once, at the middle of its bit period. That point is found by
// re-centring on the middle of the start bit.
//
// Parameters
//   OVERSAMPLE : oversample ticks per bit period (even, >= 4)
//   DATA_WIDTH : data bits per frame, sent LSB first
//   BAUD_DIV   : UCLK cycles per oversample tick (>= 2)
//
// Ports
//   UCLK       : clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   rx_dout    : last correctly framed word
//   rx_done_tk : one-cycle pulse when rx_dout is updated (FIFO write strobe)
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   busy       : high whenever a frame is in progress (state not IDLE)
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 54
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_dout,
    output logic                  rx_done_tk,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TW = $clog2(BAUD_DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(BAUD_DIV - 1);

    logic                  rx_meta;
    logic                  rx_s;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [1:0]            state;
    logic [SW-1:0]         s;
    logic [NW-1:0]         n;
    logic [DATA_WIDTH-1:0] shift_reg;

    // Two-flop synchroniser. Both flops reset to the idle level so that a
    // reset release cannot look like a start-bit falling edge.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick generator. It is never re-aligned to the
    // line. Start-bit centring absorbs the phase error, which is at most one tick.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == T_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == T_LAST);

    // Frame state machine. IDLE reacts to the falling edge on any cycle;
    // every other transition waits for a tick. START checks the line again at
    // mid-bit to reject glitches. After that, s restarts at 0, so each later
    // sample at s == OVERSAMPLE-1 falls in the middle of its bit.
    // The output pulses default low, so each one lasts exactly one cycle.
    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            s          <= '0;
            n          <= '0;
            shift_reg  <= '0;
            rx_dout    <= '0;
            rx_done_tk <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done_tk <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        s     <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s == S_HALF) begin
                            s <= '0;
                            n <= '0;
                            if (!rx_s) begin
                                state <= ST_DATA;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s         <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                            if (n == N_LAST) begin
                                state <= ST_STOP;
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            state <= ST_IDLE;
                            s     <= '0;
                            if (rx_s) begin
                                rx_dout    <= shift_reg;
                                rx_done_tk <= 1'b1;
                            end else begin
                                frame_err  <= 1'b1;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Self-checking bench for uart_rx_sampler with BAUD_DIV=4, OVERSAMPLE=16 and
// DATA_WIDTH=8, so one bit period is 64 UCLK cycles. A monitor counts output
// pulses and records the word presented with each rx_done_tk. Each scenario
// task drives the line and compares the results against hand-derived values.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int OS  = 16;
    localparam int DW  = 8;
    localparam int BD  = 4;
    localparam int BIT = OS * BD;

    logic          UCLK = 1'b0;
    logic          reset;
    logic          rx;
    logic [DW-1:0] rx_dout;
    logic          rx_done_tk;
    logic          frame_err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    int         done_cnt       = 0;
    int         err_cnt        = 0;
    int         overlap_cnt    = 0;
    int         long_pulse_cnt = 0;
    logic       prev_done      = 1'b0;
    logic       prev_err       = 1'b0;
    logic [7:0] got_q[$];

    uart_rx_sampler #(
        .OVERSAMPLE(OS),
        .DATA_WIDTH(DW),
        .BAUD_DIV  (BD)
    ) dut (
        .UCLK      (UCLK),
        .reset     (reset),
        .rx        (rx),
        .rx_dout   (rx_dout),
        .rx_done_tk(rx_done_tk),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 UCLK = ~UCLK;

    // Pulse monitor, sampled on the falling edge away from DUT updates.
    always @(negedge UCLK) begin
        if (rx_done_tk === 1'b1) begin
            done_cnt++;
            got_q.push_back(rx_dout);
        end
        if (frame_err === 1'b1) err_cnt++;
        if (rx_done_tk === 1'b1 && frame_err === 1'b1) overlap_cnt++;
        if ((rx_done_tk === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_err)) long_pulse_cnt++;
        prev_done = (rx_done_tk === 1'b1);
        prev_err  = (frame_err === 1'b1);
    end

    // Hold the line at one level for a number of cycles, ending just after an edge.
    task automatic drive(input logic b, input int cycles);
        rx = b;
        repeat (cycles) @(posedge UCLK);
        #1;
    endtask

    // One frame: start, LSB-first data, stop. No leading sync, so calls chain gaplessly.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int bit_cycles, input int stop_cycles);
        drive(1'b0, bit_cycles);
        for (int i = 0; i < DW; i++) drive(data[i], bit_cycles);
        drive(stop, stop_cycles);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rx    = 1'b1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        repeat (3) @(posedge UCLK);
        #1;
        total++; if (rx_dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout: got %h expected 00", rx_dout); end
        total++; if (rx_done_tk !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", rx_done_tk); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        drive(1'b0, 10);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_busy: got %b expected 0", busy); end
        rx = 1'b1;
        repeat (3) @(posedge UCLK);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge UCLK);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_frame();
        int d0, e0, cycles;
        d0 = done_cnt; e0 = err_cnt;
        got_q.delete();
        cycles = 0;
        @(posedge UCLK); #1;
        fork
            send_frame(8'hA5, 1'b1, BIT, BIT);
            begin
                while (1) begin
                    @(posedge UCLK); #1;
                    cycles++;
                    if ((cycles > 5 && busy === 1'b0) || cycles > 900) break;
                end
            end
        join
        repeat (20) @(posedge UCLK);
        #1;
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL single_err_count: got %0d expected 0", err_cnt - e0); end
        total++; if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin bad++; $display("[TB] FAIL single_pulse_word: got %0d words expected A5", got_q.size()); end
        total++; if (rx_dout !== 8'hA5) begin bad++; $display("[TB] FAIL single_dout: got %h expected a5", rx_dout); end
        total++; if (cycles < 9 * BIT + BIT / 2 - BD || cycles > 9 * BIT + BIT / 2 + BD) begin
            bad++; $display("[TB] FAIL single_busy_time: got %0d cycles expected 604..612", cycles);
        end
    endtask

    task automatic test_glitch();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        @(posedge UCLK); #1;
        drive(1'b0, 20);
        rx = 1'b1;
        repeat (100) @(posedge UCLK);
        #1;
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("[TB] FAIL glitch_done: got %0d expected 0", done_cnt - d0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
        total++; if (rx_dout !== 8'hA5) begin bad++; $display("[TB] FAIL glitch_dout: got %h expected a5", rx_dout); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
    endtask

    task automatic test_frame_error();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        @(posedge UCLK); #1;
        // Stop bit low only long enough to cover the mid-bit sample.
        send_frame(8'h3C, 1'b0, BIT, 40);
        repeat (150) @(posedge UCLK);
        #1;
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("[TB] FAIL ferr_err: got %0d expected 1", err_cnt - e0); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("[TB] FAIL ferr_done: got %0d expected 0", done_cnt - d0); end
        total++; if (rx_dout !== 8'hA5) begin bad++; $display("[TB] FAIL ferr_dout: got %h expected a5", rx_dout); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ferr_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_words [3];
        int d0, e0;
        exp_words[0] = 8'h00; exp_words[1] = 8'hFF; exp_words[2] = 8'h81;
        d0 = done_cnt; e0 = err_cnt;
        got_q.delete();
        @(posedge UCLK); #1;
        for (int i = 0; i < 3; i++) send_frame(exp_words[i], 1'b1, BIT, BIT);
        repeat (100) @(posedge UCLK);
        #1;
        total++; if (done_cnt - d0 !== 3) begin bad++; $display("[TB] FAIL b2b_done: got %0d expected 3", done_cnt - d0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q.size() <= i || got_q[i] !== exp_words[i]) begin
                bad++; $display("[TB] FAIL b2b_word%0d: got %0d words expected %h", i, got_q.size(), exp_words[i]);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] partial;
        int d0, e0;
        partial = 8'h5A;
        d0 = done_cnt; e0 = err_cnt;
        @(posedge UCLK); #1;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(partial[i], BIT);
        drive(partial[4], BIT / 2);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_async_busy: got %b expected 0", busy); end
        total++; if (rx_dout !== 8'h00) begin bad++; $display("[TB] FAIL mid_reset_dout: got %h expected 00", rx_dout); end
        rx = 1'b1;
        repeat (5) @(posedge UCLK);
        #1;
        reset = 1'b1;
        repeat (100) @(posedge UCLK);
        #1;
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("[TB] FAIL mid_reset_no_pulse: got %0d expected 0", done_cnt - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_idle: got %b expected 0", busy); end
        send_frame(8'h96, 1'b1, BIT, BIT);
        repeat (100) @(posedge UCLK);
        #1;
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("[TB] FAIL post_reset_done: got %0d expected 1", done_cnt - d0); end
        total++; if (rx_dout !== 8'h96) begin bad++; $display("[TB] FAIL post_reset_dout: got %h expected 96", rx_dout); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL post_reset_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_baud_error();
        logic [7:0] exp_q[$];
        int d0, e0, bit_len;
        d0 = done_cnt; e0 = err_cnt;
        got_q.delete();
        for (int g = 0; g < 2; g++) begin
            // About 3% fast, then about 3% slow.
            bit_len = (g == 0) ? 62 : 66;
            @(posedge UCLK); #1;
            for (int f = 0; f < 30; f++) begin
                logic [7:0] data;
                data = 8'($urandom_range(0, 255));
                exp_q.push_back(data);
                send_frame(data, 1'b1, bit_len, bit_len);
            end
            repeat (200) @(posedge UCLK);
        end
        #1;
        total++; if (done_cnt - d0 !== 60) begin bad++; $display("[TB] FAIL baud_done: got %0d expected 60", done_cnt - d0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL baud_err: got %0d expected 0", err_cnt - e0); end
        for (int i = 0; i < 60; i++) begin
            total++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                bad++; $display("[TB] FAIL baud_word%0d: got %0d words expected %h", i, got_q.size(), exp_q[i]);
            end
        end
    endtask

    task automatic test_pulse_shape();
        total++; if (overlap_cnt !== 0) begin bad++; $display("[TB] FAIL pulse_overlap: got %0d expected 0", overlap_cnt); end
        total++; if (long_pulse_cnt !== 0) begin bad++; $display("[TB] FAIL pulse_width: got %0d expected 0", long_pulse_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_mid_frame_reset();
        test_baud_error();
        test_pulse_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
